// File: rtl/output_fifo_buffer.sv
// output_fifo_buffer: first-word fall-through FIFO for a router output port.
// Holds up to DEPTH flits between the crossbar output and the outgoing link,
// using a valid/ready handshake on both sides. almost_full gives the switch
// allocator early warning so it can throttle.
// Optional feature macro: OUTPUT_FIFO_STALL_CNT_EN adds a saturating 16-bit
// stall_cnt output that counts cycles where out_valid && !out_ready.
module output_fifo_buffer #(
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH        = 4,
   parameter int AFULL_THRESH = DEPTH - 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   input  logic [DATA_WIDTH-1:0]        in_data,
   output logic                         in_ready,
   output logic                         out_valid,
   output logic [DATA_WIDTH-1:0]        out_data,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count,
`ifdef OUTPUT_FIFO_STALL_CNT_EN
   output logic [15:0]                  stall_cnt,
`endif
   output logic                         almost_full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_THRESH);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   logic push;
   logic pop;

   // Handshake flags come from registered occupancy only, so in_ready never
   // depends on out_ready and a pop cannot free space in the same cycle.
   always_comb begin
      in_ready    = (count_q != FULL_CNT);
      out_valid   = (count_q != '0);
      out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
      almost_full = (count_q >= AFULL_CNT);
      count       = count_q;
      push        = in_valid && in_ready;
      pop         = out_valid && out_ready;
   end

   // Next-state for pointers and occupancy; pointers wrap naturally since
   // DEPTH is a power of two and fullness is tracked by count.
   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Flit storage; writes are suppressed in the reset cycle.
   always_ff @(posedge clk) begin
      // NOTE: the memory array is deliberately not reset; stale entries are
      // unreachable because count is cleared, and out_data is gated to zero
      // while empty.
      if (rst && push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

`ifdef OUTPUT_FIFO_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   // Saturating count of cycles where a flit is offered but not taken.
   always_comb begin
      stall_d = stall_q;
      if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   // Stall counter register, cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_output_fifo_buffer.sv
// Directed self-checking bench for output_fifo_buffer at default parameters
// (DATA_WIDTH=32, DEPTH=4, AFULL_THRESH=3). Also exercises stall_cnt when
// OUTPUT_FIFO_STALL_CNT_EN is defined.
module tb_output_fifo_buffer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;
   logic [2:0]  count;
   logic        almost_full;
`ifdef OUTPUT_FIFO_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   output_fifo_buffer #(
      .DATA_WIDTH   (32),
      .DEPTH        (4),
      .AFULL_THRESH (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_ready   (out_ready),
      .count       (count),
`ifdef OUTPUT_FIFO_STALL_CNT_EN
      .stall_cnt   (stall_cnt),
`endif
      .almost_full (almost_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with its expected value and tally the result.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int tx, rx, exp_cnt;
      logic [31:0] exp_rx;

      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // Reset then idle
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("rst_out_valid",   32'(out_valid),   32'd0);
      check("rst_out_data",    out_data,         32'd0);
      check("rst_in_ready",    32'(in_ready),    32'd1);
      check("rst_count",       32'(count),       32'd0);
      check("rst_almost_full", 32'(almost_full), 32'd0);

      // Pass-through with one cycle latency
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 32'hA5A5_0001;
      tick();
      in_valid = 1'b0;
      check("pt_out_valid", 32'(out_valid), 32'd1);
      check("pt_out_data",  out_data,       32'hA5A5_0001);
      check("pt_count_n1",  32'(count),     32'd1);
      tick();
      check("pt_count_n2",  32'(count),     32'd0);
      check("pt_empty",     32'(out_valid), 32'd0);

      // Fill to full with downstream blocked; the fifth flit must be refused
      out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         in_valid = 1'b1;
         in_data  = 32'(i);
         tick();
         exp_cnt = (i > 4) ? 4 : i;
         check($sformatf("fill_count_%0d", i), 32'(count),       32'(exp_cnt));
         check($sformatf("fill_afull_%0d", i), 32'(almost_full), (exp_cnt >= 3) ? 32'd1 : 32'd0);
         check($sformatf("fill_ready_%0d", i), 32'(in_ready),    (exp_cnt == 4) ? 32'd0 : 32'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("drain_valid_%0d", k), 32'(out_valid), 32'd1);
         check($sformatf("drain_data_%0d", k),  out_data,       32'(k));
         tick();
      end
      check("drain_count", 32'(count), 32'd0);

      // Simultaneous push and pop at count=2
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h20;
      tick();
      in_data = 32'h21;
      tick();
      check("pp_count_pre", 32'(count), 32'd2);
      in_data   = 32'h22;
      out_ready = 1'b1;
      check("pp_head_popped", out_data, 32'h20);
      tick();
      in_valid = 1'b0;
      check("pp_count_post", 32'(count), 32'd2);
      check("pp_head_next",  out_data,   32'h21);
      tick();
      check("pp_tail",       out_data,   32'h22);
      tick();
      check("pp_empty",      32'(count), 32'd0);

      // Wrap-around stream with out_ready toggling 1,0,1,0
      tx     = 0;
      rx     = 0;
      exp_rx = 32'h10;
      for (int cyc = 0; cyc < 200 && rx < 10; cyc++) begin
         in_valid  = (tx < 10);
         in_data   = 32'h10 + 32'(tx);
         out_ready = (cyc % 2 == 0);
         if (out_valid && out_ready) begin
            check($sformatf("wrap_rx_%0d", rx), out_data, exp_rx);
            exp_rx++;
            rx++;
         end
         if (in_valid && in_ready) tx++;
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("wrap_rx_total", 32'(rx),    32'd10);
      check("wrap_empty",    32'(count), 32'd0);

      // Reset mid-operation with count=3 and a flit in flight
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 32'h30 + 32'(i);
         tick();
      end
      check("mid_count_pre", 32'(count), 32'd3);
      in_data = 32'h33;
      rst     = 1'b0;
      tick();
      rst      = 1'b1;
      in_valid = 1'b0;
      check("mid_count",     32'(count),       32'd0);
      check("mid_out_valid", 32'(out_valid),   32'd0);
      check("mid_out_data",  out_data,         32'd0);
      check("mid_in_ready",  32'(in_ready),    32'd1);
      check("mid_afull",     32'(almost_full), 32'd0);
`ifdef OUTPUT_FIFO_STALL_CNT_EN
      check("stall_after_rst", 32'(stall_cnt), 32'd0);
`endif
      in_valid = 1'b1;
      in_data  = 32'h40;
      tick();
      in_valid = 1'b0;
      check("post_rst_head",  out_data,   32'h40);
      check("post_rst_count", 32'(count), 32'd1);
      for (int i = 0; i < 5; i++) tick();
`ifdef OUTPUT_FIFO_STALL_CNT_EN
      check("stall_five", 32'(stall_cnt), 32'd5);
`endif
      check("hold_head", out_data, 32'h40);
      out_ready = 1'b1;
      tick();
      check("final_empty", 32'(count), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
